// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: state encoding and bus widths.
package dmem_arb_pkg;

   localparam int DMEM_AW = 32;
   localparam int DMEM_DW = 32;

   localparam logic [1:0] ARB_IDLE = 2'd0;
   localparam logic [1:0] ARB_OWN0 = 2'd1;
   localparam logic [1:0] ARB_OWN1 = 2'd2;

   typedef enum logic [1:0] {
      OWN_IDLE = ARB_IDLE,
      OWN_P0   = ARB_OWN0,
      OWN_P1   = ARB_OWN1
   } own_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the two-port data-memory arbiter.
interface dmem_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int AW = DMEM_AW,
   parameter int DW = DMEM_DW
);

   logic          m0_req;
   logic          m0_we;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic          m0_gnt;
   logic          m0_rvalid;
   logic [DW-1:0] m0_rdata;

   logic          m1_req;
   logic          m1_we;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic          m1_gnt;
   logic          m1_rvalid;
   logic [DW-1:0] m1_rdata;

   logic          mem_ce;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   // arbiter side
   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_ce, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // requesters plus the memory itself
   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_ce, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_arb_rsp.sv
// Per-port read response register: captures mem_rdata at the end of a read
// grant and presents it with a one-cycle rvalid pulse.
module dmem_arb_rsp
   import dmem_arb_pkg::*;
#(
   parameter int DW = DMEM_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cap,
   input  logic [DW-1:0] mem_rdata,
   output logic          rvalid,
   output logic [DW-1:0] rdata
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= cap;
         if (cap) rdata <= mem_rdata;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Burst-limited round-robin arbiter sharing data_mem between the core (port 0)
// and a secondary master (port 1); one access per cycle, reads return next cycle.
//
//   state    | meaning
//   OWN_IDLE | no access last cycle; port 0 wins a tie
//   OWN_P0   | port 0 granted last cycle; cnt = its consecutive grants
//   OWN_P1   | port 1 granted last cycle; cnt = its consecutive grants
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW        = DMEM_AW,
   parameter int DW        = DMEM_DW,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus
);

   localparam int            CW      = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

   own_e          own, own_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          gnt0, gnt1;
   logic          we_sel;
   logic [AW-1:0] addr_sel;
   logic [DW-1:0] wdata_sel;

   always_ff @(posedge clk) begin
      if (!rst) begin
         own <= OWN_IDLE;
         cnt <= '0;
      end else begin
         own <= own_nxt;
         cnt <= cnt_nxt;
      end
   end

   always_comb begin
      own_nxt = own;
      cnt_nxt = cnt;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      case (own)
         OWN_IDLE: begin
            if (bus.m0_req) begin
               gnt0    = 1'b1;
               own_nxt = OWN_P0;
               cnt_nxt = CW'(1);
            end else if (bus.m1_req) begin
               gnt1    = 1'b1;
               own_nxt = OWN_P1;
               cnt_nxt = CW'(1);
            end
         end
         OWN_P0: begin
            // owner keeps the bus until its burst is spent and the other side waits
            if (bus.m0_req && ((cnt < CNT_MAX) || !bus.m1_req)) begin
               gnt0 = 1'b1;
               if (cnt < CNT_MAX) cnt_nxt = cnt + CW'(1);
            end else if (bus.m1_req) begin
               gnt1    = 1'b1;
               own_nxt = OWN_P1;
               cnt_nxt = CW'(1);
            end else begin
               own_nxt = OWN_IDLE;
               cnt_nxt = '0;
            end
         end
         OWN_P1: begin
            if (bus.m1_req && ((cnt < CNT_MAX) || !bus.m0_req)) begin
               gnt1 = 1'b1;
               if (cnt < CNT_MAX) cnt_nxt = cnt + CW'(1);
            end else if (bus.m0_req) begin
               gnt0    = 1'b1;
               own_nxt = OWN_P0;
               cnt_nxt = CW'(1);
            end else begin
               own_nxt = OWN_IDLE;
               cnt_nxt = '0;
            end
         end
         default: begin
            own_nxt = OWN_IDLE;
            cnt_nxt = '0;
         end
      endcase
      if (!rst) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   always_comb begin
      we_sel    = 1'b0;
      addr_sel  = '0;
      wdata_sel = '0;
      if (gnt0) begin
         we_sel    = bus.m0_we;
         addr_sel  = bus.m0_addr;
         wdata_sel = bus.m0_wdata;
      end else if (gnt1) begin
         we_sel    = bus.m1_we;
         addr_sel  = bus.m1_addr;
         wdata_sel = bus.m1_wdata;
      end
   end

   assign bus.m0_gnt    = gnt0;
   assign bus.m1_gnt    = gnt1;
   assign bus.mem_ce    = gnt0 | gnt1;
   assign bus.mem_we    = we_sel;
   assign bus.mem_addr  = addr_sel;
   assign bus.mem_wdata = wdata_sel;

   dmem_arb_rsp #(.DW(DW)) u_rsp0 (
      .clk       (clk),
      .rst       (rst),
      .cap       (gnt0 & ~bus.m0_we),
      .mem_rdata (bus.mem_rdata),
      .rvalid    (bus.m0_rvalid),
      .rdata     (bus.m0_rdata)
   );

   dmem_arb_rsp #(.DW(DW)) u_rsp1 (
      .clk       (clk),
      .rst       (rst),
      .cap       (gnt1 & ~bus.m1_we),
      .mem_rdata (bus.mem_rdata),
      .rvalid    (bus.m1_rvalid),
      .rdata     (bus.m1_rdata)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a reference model predicts grants, memory
// traffic and read responses per cycle; a negedge monitor pops and compares.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int MAXB = 4;

   typedef struct packed {
      logic        g0, g1, ce, we;
      logic [31:0] addr, wdata;
      logic        rv0, rv1;
      logic [31:0] rd0, rd1;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

   dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(MAXB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // memory harness: combinational read, write at the end of the grant cycle
   logic [31:0] mem [16];
   assign bus.mem_rdata = mem[bus.mem_addr[5:2]];
   always @(posedge clk) if (bus.mem_ce && bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;

   // reference model: who owned the bus last cycle and for how many cycles in a row
   int          owner = -1;
   int          run   = 0;
   int          g     = -1;
   int          last_g = -1;
   logic        g_we;
   logic [31:0] g_addr, g_wdata;
   logic [31:0] ref_mem [16];
   logic [31:0] rd [2];
   logic        rv [2];
   logic [31:0] rdq0 [$];
   logic [31:0] rdq1 [$];
   exp_t        expq [$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic model_edge(input logic rst_s);
      rv[0] = 1'b0;
      rv[1] = 1'b0;
      if (!rst_s) begin
         owner = -1;
         run   = 0;
         rd[0] = '0;
         rd[1] = '0;
      end else begin
         if (g >= 0 && g_we) ref_mem[g_addr[5:2]] = g_wdata;
         else if (g >= 0) begin
            rv[g] = 1'b1;
            rd[g] = ref_mem[g_addr[5:2]];
            if (g == 0) rdq0.push_back(rd[0]);
            else rdq1.push_back(rd[1]);
         end
         if (g < 0) begin
            owner = -1;
            run   = 0;
         end else if (g == owner) begin
            if (run < MAXB) run++;
         end else begin
            owner = g;
            run   = 1;
         end
      end
   endtask

   task automatic model_comb(input logic r0, input logic r1, input logic rst_s);
      bit   rq [2];
      exp_t e;
      rq[0] = r0;
      rq[1] = r1;
      g = -1;
      if (rst_s) begin
         if (owner < 0) g = r0 ? 0 : (r1 ? 1 : -1);
         else if (rq[owner] && (run < MAXB || !rq[1-owner])) g = owner;
         else if (rq[1-owner]) g = 1 - owner;
      end
      g_we    = (g == 0) ? bus.m0_we    : (g == 1) ? bus.m1_we    : 1'b0;
      g_addr  = (g == 0) ? bus.m0_addr  : (g == 1) ? bus.m1_addr  : 32'h0;
      g_wdata = (g == 0) ? bus.m0_wdata : (g == 1) ? bus.m1_wdata : 32'h0;
      e.g0 = (g == 0);
      e.g1 = (g == 1);
      e.ce = (g >= 0);
      e.we = g_we;
      e.addr = g_addr;
      e.wdata = g_wdata;
      e.rv0 = rv[0];
      e.rv1 = rv[1];
      e.rd0 = rd[0];
      e.rd1 = rd[1];
      expq.push_back(e);
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("m0_gnt", bus.m0_gnt, e.g0);
            chk("m1_gnt", bus.m1_gnt, e.g1);
            chk("mem_ce", bus.mem_ce, e.ce);
            chk("mem_we", bus.mem_we, e.we);
            chk("mem_addr", bus.mem_addr, e.addr);
            chk("mem_wdata", bus.mem_wdata, e.wdata);
            chk("m0_rvalid", bus.m0_rvalid, e.rv0);
            chk("m1_rvalid", bus.m1_rvalid, e.rv1);
            chk("m0_rdata_hold", bus.m0_rdata, e.rd0);
            chk("m1_rdata_hold", bus.m1_rdata, e.rd1);
            if (bus.m0_rvalid === 1'b1) begin
               if (rdq0.size() == 0) chk("m0_rsp_unexpected", 32'd1, 32'd0);
               else chk("m0_rsp_data", bus.m0_rdata, rdq0.pop_front());
            end else if (e.rv0 && rdq0.size() > 0) void'(rdq0.pop_front());
            if (bus.m1_rvalid === 1'b1) begin
               if (rdq1.size() == 0) chk("m1_rsp_unexpected", 32'd1, 32'd0);
               else chk("m1_rsp_data", bus.m1_rdata, rdq1.pop_front());
            end else if (e.rv1 && rdq1.size() > 0) void'(rdq1.pop_front());
         end
      end
   end

   task automatic edge_tick();
      @(posedge clk);
      last_g = g;
      model_edge(rst);
      #1;
   endtask

   task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic rs);
      rst          = rs;
      bus.m0_req   = r0;
      bus.m0_we    = w0;
      bus.m0_addr  = a0;
      bus.m0_wdata = d0;
      bus.m1_req   = r1;
      bus.m1_we    = w1;
      bus.m1_addr  = a1;
      bus.m1_wdata = d1;
      model_comb(r0, r1, rs);
   endtask

   task automatic cyc(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic rs);
      edge_tick();
      drive(r0, w0, a0, d0, r1, w1, a1, d1, rs);
   endtask

   task automatic idle_cyc();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      logic [1:0] seq [9];
      bit         act [2];
      logic       pwe [2];
      logic [31:0] pad [2];
      logic [31:0] pwd [2];
      int         prob [2];
      int         w;
      bit         got;

      for (int i = 0; i < 16; i++) begin
         mem[i]     = 32'h1000_0000 + 32'(i);
         ref_mem[i] = 32'h1000_0000 + 32'(i);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      void'(expq.pop_front());

      // reset held with both ports requesting
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0, 0);
         #2;
         chk("rst_m0_gnt", bus.m0_gnt, 0);
         chk("rst_m1_gnt", bus.m1_gnt, 0);
         chk("rst_mem_ce", bus.mem_ce, 0);
      end
      cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0, 1);
      #2;
      chk("rst_release_m0_gnt", bus.m0_gnt, 1);
      idle_cyc();

      // continuous contention from idle
      seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
      for (int i = 0; i < 9; i++) begin
         cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0, 1);
         #2;
         chk("contention_gnt", {bus.m1_gnt, bus.m0_gnt}, seq[i]);
         chk("contention_ce", bus.mem_ce, 1);
      end
      idle_cyc();

      // single read after a port 1 write
      cyc(0, 0, 0, 0, 1, 1, 32'h10, 32'h0000_00A5, 1);
      #2;
      chk("wr_m1_gnt", bus.m1_gnt, 1);
      cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, 1);
      #2;
      chk("rd_m0_gnt", bus.m0_gnt, 1);
      idle_cyc();
      #2;
      chk("rd_m0_rvalid", bus.m0_rvalid, 1);
      chk("rd_m0_rdata", bus.m0_rdata, 32'h0000_00A5);
      chk("rd_m1_rvalid", bus.m1_rvalid, 0);

      // solo burst, then port 1 joins
      for (int i = 0; i < 10; i++) begin
         cyc(1, 0, 32'(i % 16) * 4, 0, 0, 0, 0, 0, 1);
         #2;
         chk("solo_m0_gnt", bus.m0_gnt, 1);
      end
      w = 0;
      got = 0;
      while (!got && w < 6) begin
         cyc(1, 0, 32'h0, 0, 1, 0, 32'h8, 0, 1);
         w++;
         #2;
         got = bus.m1_gnt;
      end
      chk("solo_m1_wait_le4", (got && w <= MAXB) ? 1 : 0, 1);
      idle_cyc();
      idle_cyc();

      // short-lived port 1 request while port 0 owns the bus
      cyc(1, 0, 32'h8, 0, 0, 0, 0, 0, 1);
      cyc(1, 0, 32'h8, 0, 1, 1, 32'h20, 32'hDEAD_BEEF, 1);
      #2;
      chk("wd_m1_gnt", bus.m1_gnt, 0);
      chk("wd_mem_we", bus.mem_we, 0);
      cyc(1, 0, 32'h8, 0, 0, 0, 0, 0, 1);
      #2;
      chk("wd_m1_gnt2", bus.m1_gnt, 0);
      idle_cyc();
      idle_cyc();
      #2;
      chk("wd_idle_ce", bus.mem_ce, 0);

      // reset landing on the edge that ends a read grant
      cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, 1);
      #2;
      chk("rmr_m0_gnt", bus.m0_gnt, 1);
      @(negedge clk);
      #1;
      rst = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("rmr_m0_rvalid", bus.m0_rvalid, 0);
      idle_cyc();
      cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, 1);
      idle_cyc();
      #2;
      chk("rmr_fresh_rvalid", bus.m0_rvalid, 1);
      chk("rmr_fresh_rdata", bus.m0_rdata, 32'h0000_00A5);

      // randomized traffic, four load phases
      act = '{0, 0};
      for (int i = 0; i < 600; i++) begin
         case (i / 150)
            0: prob = '{90, 90};
            1: prob = '{30, 80};
            2: prob = '{100, 100};
            default: prob = '{50, 50};
         endcase
         edge_tick();
         for (int p = 0; p < 2; p++) begin
            if (last_g == p) act[p] = 0;
            if (!act[p]) begin
               if (int'($urandom_range(0, 99)) < prob[p]) begin
                  act[p] = 1;
                  pwe[p] = 1'($urandom_range(0, 1));
                  pad[p] = 32'($urandom_range(0, 15)) * 4;
                  pwd[p] = $urandom;
               end
            end else if ($urandom_range(0, 15) == 0) act[p] = 0;
         end
         drive(act[0], pwe[0], pad[0], pwd[0], act[1], pwe[1], pad[1], pwd[1], 1);
      end
      idle_cyc();
      idle_cyc();
      @(negedge clk);
      #1;
      chk("rsp_queue_drain", 32'(rdq0.size() + rdq1.size()), 0);
      chk("exp_queue_drain", 32'(expq.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-ported `data_mem` between the `riscv` core's data port (port 0) and a secondary bus master (port 1), such as a program loader or debug module. It sits between the requesters and `data_mem`. It grants one access per cycle using burst-limited round-robin and returns registered read data one cycle after the grant. Requesters hold their request until granted, so the core stalls on `m0_gnt` low.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `MAX_BURST`, 4: maximum consecutive grants to one port while the other port is requesting; ≥1.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `m0_req`  in  1  port 0 access request; held until `m0_gnt`.
- `m0_we`  in  1  port 0 write enable (1 = write, 0 = read).
- `m0_addr`  in  AW  port 0 byte address.
- `m0_wdata`  in  DW  port 0 write data.
- `m0_gnt`  out  1  port 0 access accepted this cycle.
- `m0_rvalid`  out  1  port 0 read data valid.
- `m0_rdata`  out  DW  port 0 read data.
- `m1_*`: same seven signals for port 1.
- `mem_ce`  out  1  memory enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data (combinational in `mem_addr`).

## Operation
- State register `own` ∈ {IDLE, OWN0, OWN1} and saturating burst counter `cnt` (width clog2(MAX_BURST+1)).
- Grant logic is combinational from `own`, `cnt`, `m0_req` and `m1_req`. At most one `gnt` is high per cycle.
- **IDLE**:
  - `m0_req` → grant 0, next OWN0, `cnt`=1.
  - Else `m1_req` → grant 1, next OWN1, `cnt`=1.
  - Else no grant.
  - A tie goes to port 0.
- **OWN0**:
  - `m0_req` and (`cnt`<MAX_BURST or !`m1_req`) → grant 0, `cnt`=min(`cnt`+1, MAX_BURST).
  - Else `m1_req` → grant 1, next OWN1, `cnt`=1.
  - Else no grant, next IDLE, `cnt`=0.
- **OWN1**: symmetric with port 0 and port 1 swapped.
- Memory mux:
  - `mem_ce` = `m0_gnt` | `m1_gnt`.
  - `mem_we`/`mem_addr`/`mem_wdata` come from the granted port.
  - All are 0 when there is no grant.
- **Writes**: committed by `data_mem` at the rising edge that ends the grant cycle. No response is produced.
- **Reads**: at the end of the grant cycle, `mem_rdata` is captured into the granted port's `rdata` register, and that port's `rvalid` is 1 for exactly the next cycle.
  - `rdata` holds its value until the next read for that port.
  - `rvalid` for the port not granted is 0.
- An ungranted requester keeps `req`, `we`, `addr` and `wdata` stable. Changing them before grant is a protocol violation and is not detected.
- Dropping `req` before grant is allowed: the request is withdrawn and nothing is accessed.

## Timing
- Reset (`rst`=0 at an edge):
  - `own`=IDLE, `cnt`=0.
  - `m0_rvalid`=`m1_rvalid`=0, `m0_rdata`=`m1_rdata`=0.
  - Combinational outputs follow from IDLE.
  - During reset, `m*_gnt` and `mem_ce` are forced to 0.
- Reset asserted the cycle after a read grant: `rvalid` is 0 after that edge and the read response is lost.
- Latency: grant in cycle N when the port wins arbitration; read data valid in cycle N+1.
- Throughput: one access per cycle. Back-to-back grants are allowed with no idle cycle on a port switch.
- Worst-case wait for a continuously requesting port: MAX_BURST cycles.
- Counter saturates at MAX_BURST while the other port is idle, so a solo requester keeps an uninterrupted grant.

## Structure
- Package `dmem_arb_pkg`:
  - state encoding localparams `ARB_IDLE`=2'd0, `ARB_OWN0`=2'd1, `ARB_OWN1`=2'd2.
  - `DMEM_AW`/`DMEM_DW` defaults.
- Sub-module `dmem_arb_rsp`, instantiated once per port:
  - inputs: capture strobe (`gnt & !we`) and `mem_rdata`.
  - outputs: registered `rvalid`/`rdata`.
  - same reset rules as above.
- Arbitration FSM, counter and memory mux stay in `dmem_arbiter`.

## Test plan
- **Reset**: hold `rst`=0 for 3 cycles with both `req`=1 → all `gnt`, `rvalid`, `mem_ce` are 0 and `rdata`=0; release → port 0 granted in the first cycle.
- **Single read**: write 0x0000_00A5 to addr 0x10 via port 1, then port 0 reads 0x10 → `m0_gnt` in cycle N, `m0_rvalid`=1 with `m0_rdata`=0x0000_00A5 in N+1, `m1_rvalid`=0.
- **Contention**, MAX_BURST=4, both requesting continuously from IDLE → grant sequence 0,0,0,0,1,1,1,1,0, with `mem_ce`=1 every cycle.
- **Solo burst**: port 0 requests 10 consecutive cycles, port 1 idle → 10 consecutive `m0_gnt`; port 1 then asserts `req` → it is granted after at most 4 cycles.
- **Withdrawal and idle**: port 1 raises `req` for one cycle while port 0 holds the bus and `cnt`<MAX_BURST, then drops it → no `m1_gnt`, `mem_we` never driven from port 1; both idle → state returns to IDLE, `mem_ce`=0.
- **Reset mid-read**: port 0 read granted in cycle N, `rst`=0 at the edge ending N → `m0_rvalid`=0 in N+1; after release, a fresh port 0 read returns correct data.
